// File: rtl/bus_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_port_ctrl
//  Description : Framed, buffered TX/RX endpoint for the shared interconnect
//                data bus. TX queues client words, requests the bus and sends
//                a Gray-coded destination header followed by the payload. RX
//                snoops the bus and buffers frames addressed to NODE_ID.
//                Optional macro BUS_BROADCAST_EN: destination all-ones is a
//                broadcast received by every port except the sender.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_port_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ID_W     = 2,
    parameter int NODE_ID  = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [ID_W-1:0]   tx_dest,
    input  logic              tx_last,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic [ID_W-1:0]   rx_src,
    output logic              rx_last,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_out_en,
    output logic [DATA_W-1:0] bus_out_data,
    output logic              bus_out_valid,
    output logic              bus_out_last,
    input  logic [DATA_W-1:0] bus_in_data,
    input  logic              bus_in_valid,
    input  logic              bus_in_last,
    input  logic              bus_stall_in,
    output logic              bus_stall_out
);
    localparam int c_tx_aw = $clog2(TX_DEPTH);
    localparam int c_rx_aw = $clog2(RX_DEPTH);
    localparam int c_ew    = DATA_W + ID_W + 1;
    localparam logic [ID_W-1:0] c_node_id = ID_W'(NODE_ID);

    typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_HDR, TX_DATA} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_SKIP} rx_state_t;

    function automatic logic [ID_W-1:0] gray2bin(input logic [ID_W-1:0] g);
        logic [ID_W-1:0] b;
        b = g;
        for (int i = ID_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    tx_state_t tx_state_q, tx_state_d;
    rx_state_t rx_state_q, rx_state_d;

    logic [c_ew-1:0]    tx_mem_q [TX_DEPTH];
    logic [c_ew-1:0]    rx_mem_q [RX_DEPTH];
    logic [c_tx_aw:0]   tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [c_rx_aw:0]   rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [ID_W-1:0]    rx_src_cap_q, rx_src_cap_d;
    logic               tx_en_q, tx_en_d;

    logic               tx_full, tx_empty, tx_push, tx_pop;
    logic               rx_full, rx_empty, rx_push, rx_pop;
    logic [DATA_W-1:0]  tx_head_data, rx_head_data, hdr;
    logic [ID_W-1:0]    tx_head_dest, rx_head_src, in_dest_bin, in_src;
    logic               tx_head_last, rx_head_last, dest_match, own_hdr, bus_beat;

    // ---------------- TX FIFO ----------------
    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[c_tx_aw] != tx_rp_q[c_tx_aw]) &&
                      (tx_wp_q[c_tx_aw-1:0] == tx_rp_q[c_tx_aw-1:0]);
    // tx_en_q keeps tx_ready low for the cycle following reset
    assign tx_ready = tx_en_q && !tx_full;
    assign tx_push  = tx_valid && tx_ready;
    assign {tx_head_data, tx_head_dest, tx_head_last} = tx_mem_q[tx_rp_q[c_tx_aw-1:0]];

    // Header: gray(dest) on top, own binary ID below, zeros elsewhere
    always_comb begin
        hdr = '0;
        hdr[DATA_W-1 -: ID_W]      = tx_head_dest ^ (tx_head_dest >> 1);
        hdr[DATA_W-ID_W-1 -: ID_W] = c_node_id;
    end

    // TX FSM next state and bus drive; a stall freezes the head so outputs hold
    always_comb begin
        tx_state_d    = tx_state_q;
        tx_pop        = 1'b0;
        bus_req       = 1'b0;
        bus_out_en    = 1'b0;
        bus_out_valid = 1'b0;
        bus_out_data  = '0;
        bus_out_last  = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (!tx_empty) tx_state_d = TX_REQ;
            TX_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) tx_state_d = TX_HDR;
            end
            TX_HDR: begin
                bus_req       = 1'b1;
                bus_out_en    = 1'b1;
                bus_out_valid = 1'b1;
                bus_out_data  = hdr;
                if (!bus_stall_in) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                bus_req    = 1'b1;
                bus_out_en = 1'b1;
                if (!tx_empty) begin
                    bus_out_valid = 1'b1;
                    bus_out_data  = tx_head_data;
                    bus_out_last  = tx_head_last;
                    if (!bus_stall_in) begin
                        tx_pop = 1'b1;
                        if (tx_head_last) tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX pointer update
    always_comb begin
        tx_wp_d = tx_wp_q + (c_tx_aw+1)'(tx_push);
        tx_rp_d = tx_rp_q + (c_tx_aw+1)'(tx_pop);
        tx_en_d = 1'b1;
    end

    // ---------------- RX side ----------------
    assign in_dest_bin = gray2bin(bus_in_data[DATA_W-1 -: ID_W]);
    assign in_src      = bus_in_data[DATA_W-ID_W-1 -: ID_W];
    assign own_hdr     = (tx_state_q == TX_HDR);
    assign bus_beat    = bus_in_valid && !bus_stall_in;
`ifdef BUS_BROADCAST_EN
    assign dest_match  = (in_dest_bin == c_node_id) || (&in_dest_bin);
`else
    assign dest_match  = (in_dest_bin == c_node_id);
`endif

    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[c_rx_aw] != rx_rp_q[c_rx_aw]) &&
                      (rx_wp_q[c_rx_aw-1:0] == rx_rp_q[c_rx_aw-1:0]);
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;
    // bus_stall_in carries this port's own stall, so a full FIFO never sees a push
    assign bus_stall_out = (rx_state_q == RX_RECV) && rx_full && bus_in_valid;
    assign {rx_head_data, rx_head_src, rx_head_last} = rx_mem_q[rx_rp_q[c_rx_aw-1:0]];
    assign rx_data  = rx_valid ? rx_head_data : '0;
    assign rx_src   = rx_valid ? rx_head_src  : '0;
    assign rx_last  = rx_valid && rx_head_last;

    // RX FSM: headers only advance on non-stalled beats so a held header is seen once
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_src_cap_d = rx_src_cap_q;
        rx_push      = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (bus_beat) begin
                if (own_hdr || !dest_match) begin
                    rx_state_d = RX_SKIP;
                end else begin
                    rx_state_d   = RX_RECV;
                    rx_src_cap_d = in_src;
                end
            end
            RX_RECV: if (bus_beat) begin
                rx_push = 1'b1;
                if (bus_in_last) rx_state_d = RX_IDLE;
            end
            RX_SKIP: if (bus_beat && bus_in_last) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX pointer update
    always_comb begin
        rx_wp_d = rx_wp_q + (c_rx_aw+1)'(rx_push);
        rx_rp_d = rx_rp_q + (c_rx_aw+1)'(rx_pop);
    end

    // State and pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q   <= TX_IDLE;
            rx_state_q   <= RX_IDLE;
            tx_wp_q      <= '0;
            tx_rp_q      <= '0;
            rx_wp_q      <= '0;
            rx_rp_q      <= '0;
            rx_src_cap_q <= '0;
            tx_en_q      <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            rx_state_q   <= rx_state_d;
            tx_wp_q      <= tx_wp_d;
            tx_rp_q      <= tx_rp_d;
            rx_wp_q      <= rx_wp_d;
            rx_rp_q      <= rx_rp_d;
            rx_src_cap_q <= rx_src_cap_d;
            tx_en_q      <= tx_en_d;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q[c_tx_aw-1:0]] <= {tx_data, tx_dest, tx_last};
        if (rx_push) rx_mem_q[rx_wp_q[c_rx_aw-1:0]] <= {bus_in_data, rx_src_cap_q, bus_in_last};
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_port_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_port_ctrl
//  Description : Four bus_port_ctrl nodes (IDs 0..3) on a muxed shared bus.
//                Directed frames with hand-computed expected values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_port_ctrl;
    logic             clk, reset;
    logic [3:0]       tx_valid, tx_ready, tx_last, rx_valid, rx_ready, rx_last;
    logic [3:0]       bus_req, bus_gnt, out_en, out_valid, out_last, stall_out;
    logic [3:0][7:0]  tx_data, rx_data, out_data;
    logic [3:0][1:0]  tx_dest, rx_src;
    logic [7:0]       bus_data;
    logic             bus_valid, bus_last, bus_stall;
    int               n_tests, n_fail;

    for (genvar g = 0; g < 4; g++) begin : g_node
        bus_port_ctrl #(.DATA_W(8), .ID_W(2), .NODE_ID(g), .TX_DEPTH(4), .RX_DEPTH(4)) u_dut (
            .clk(clk), .reset(reset),
            .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]), .tx_data(tx_data[g]),
            .tx_dest(tx_dest[g]), .tx_last(tx_last[g]),
            .rx_valid(rx_valid[g]), .rx_ready(rx_ready[g]), .rx_data(rx_data[g]),
            .rx_src(rx_src[g]), .rx_last(rx_last[g]),
            .bus_req(bus_req[g]), .bus_gnt(bus_gnt[g]), .bus_out_en(out_en[g]),
            .bus_out_data(out_data[g]), .bus_out_valid(out_valid[g]), .bus_out_last(out_last[g]),
            .bus_in_data(bus_data), .bus_in_valid(bus_valid), .bus_in_last(bus_last),
            .bus_stall_in(bus_stall), .bus_stall_out(stall_out[g])
        );
    end

    // Top-level bus mux driven by whichever port holds the drive enable
    always_comb begin
        bus_data  = '0;
        bus_valid = 1'b0;
        bus_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_en[i]) begin
                bus_data  = out_data[i];
                bus_valid = out_valid[i];
                bus_last  = out_last[i];
            end
        end
    end
    assign bus_stall = |stall_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n, input logic [7:0] d, input logic [1:0] dst, input logic l);
        int k;
        tx_valid[n] = 1'b1;
        tx_data[n]  = d;
        tx_dest[n]  = dst;
        tx_last[n]  = l;
        for (k = 0; k < 100 && !tx_ready[n]; k++) tick();
        check("push_ready", {31'd0, tx_ready[n]}, 32'd1);
        tick();
        tx_valid[n] = 1'b0;
        tx_last[n]  = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int k;
        for (k = 0; k < 100 && !rx_valid[n]; k++) tick();
        check("rx_wait", {31'd0, rx_valid[n]}, 32'd1);
    endtask

    task automatic pop(input int n, input logic [7:0] d, input logic [1:0] s, input logic l);
        check("rx_data", {24'd0, rx_data[n]}, {24'd0, d});
        check("rx_src",  {30'd0, rx_src[n]},  {30'd0, s});
        check("rx_last", {31'd0, rx_last[n]}, {31'd0, l});
        rx_ready[n] = 1'b1;
        tick();
        rx_ready[n] = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        tx_valid = '0; tx_last = '0; tx_data = '0; tx_dest = '0;
        rx_ready = '0; bus_gnt = '0;
        reset = 1'b1;
        tick(); tick();
        // Reset state
        check("rst_req",    {28'd0, bus_req},  32'd0);
        check("rst_out_en", {28'd0, out_en},   32'd0);
        check("rst_txrdy",  {28'd0, tx_ready}, 32'd0);
        check("rst_rxval",  {28'd0, rx_valid}, 32'd0);
        check("rst_rxsrc",  {24'd0, rx_src},   32'd0);
        reset = 1'b0;
        tick();
        check("txrdy_up", {28'd0, tx_ready}, 32'hF);

        // Node 1 sends 0x11,0x22,0x33 to node 2; header gray(2)=3, src 1 -> 0xD0
        bus_gnt = 4'b0010;
        tx_valid[1] = 1'b1; tx_dest[1] = 2'd2; tx_data[1] = 8'h11; tx_last[1] = 1'b0;
        tick();
        tx_data[1] = 8'h22;
        tick();
        tx_data[1] = 8'h33; tx_last[1] = 1'b1;
        tick();
        tx_valid[1] = 1'b0; tx_last[1] = 1'b0;
        check("hdr_data",  {24'd0, bus_data}, 32'hD0);
        check("hdr_valid", {31'd0, bus_valid}, 32'd1);
        check("hdr_last",  {31'd0, bus_last}, 32'd0);
        tick();
        check("p0_data", {24'd0, bus_data}, 32'h11);
        check("p0_last", {31'd0, bus_last}, 32'd0);
        tick();
        check("p1_data", {24'd0, bus_data}, 32'h22);
        tick();
        check("p2_data", {24'd0, bus_data}, 32'h33);
        check("p2_last", {31'd0, bus_last}, 32'd1);
        check("p2_req",  {31'd0, bus_req[1]}, 32'd1);
        tick();
        check("req_drop", {31'd0, bus_req[1]}, 32'd0);
        check("en_drop",  {31'd0, out_en[1]}, 32'd0);
        check("self_rx",  {31'd0, rx_valid[1]}, 32'd0);
        pop(2, 8'h11, 2'd1, 1'b0);
        pop(2, 8'h22, 2'd1, 1'b0);
        pop(2, 8'h33, 2'd1, 1'b1);
        check("n2_empty", {31'd0, rx_valid[2]}, 32'd0);

        // Single-word loopback 1 -> 2
        push(1, 8'hA5, 2'd2, 1'b1);
        wait_rx(2);
        pop(2, 8'hA5, 2'd1, 1'b1);
        check("lb_n1_rx", {31'd0, rx_valid[1]}, 32'd0);

        // Backpressure: 6-word frame into a 4-deep RX FIFO with rx_ready low
        for (int i = 1; i <= 6; i++) push(1, 8'(i), 2'd2, i == 6);
        for (int k = 0; k < 50 && !stall_out[2]; k++) tick();
        check("stall_on",   {31'd0, stall_out[2]}, 32'd1);
        check("stall_word", {24'd0, bus_data}, 32'h05);
        tick(); tick(); tick();
        check("stall_hold", {24'd0, bus_data}, 32'h05);
        check("stall_vld",  {31'd0, bus_valid}, 32'd1);
        for (int i = 1; i <= 6; i++) begin
            wait_rx(2);
            pop(2, 8'(i), 2'd1, i == 6);
        end

        // Frame for node 3 is skipped by node 2, which then takes its own frame
        push(1, 8'h31, 2'd3, 1'b0);
        push(1, 8'h32, 2'd3, 1'b1);
        wait_rx(3);
        for (int k = 0; k < 4; k++) tick();
        check("skip_n2", {31'd0, rx_valid[2]}, 32'd0);
        pop(3, 8'h31, 2'd1, 1'b0);
        pop(3, 8'h32, 2'd1, 1'b1);
        push(1, 8'h77, 2'd2, 1'b1);
        wait_rx(2);
        pop(2, 8'h77, 2'd1, 1'b1);

        // Grant withheld: request stays up, bus not driven, FIFO fills
        bus_gnt = 4'b0000;
        for (int i = 0; i < 4; i++) push(1, 8'h41 + 8'(i), 2'd2, i == 3);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("nogt_req", {31'd0, bus_req[1]}, 32'd1);
            check("nogt_en",  {31'd0, out_en[1]}, 32'd0);
        end
        check("nogt_full", {31'd0, tx_ready[1]}, 32'd0);
        bus_gnt = 4'b0010;
        for (int k = 0; k < 20 && !(out_valid[1] && out_data[1] == 8'h41); k++) tick();
        check("mid_data", {24'd0, bus_data}, 32'h41);
        reset = 1'b1;
        tick();
        check("mr_req",   {31'd0, bus_req[1]},   32'd0);
        check("mr_en",    {31'd0, out_en[1]},    32'd0);
        check("mr_vld",   {31'd0, out_valid[1]}, 32'd0);
        check("mr_data",  {24'd0, out_data[1]},  32'd0);
        check("mr_txrdy", {31'd0, tx_ready[1]},  32'd0);
        check("mr_rx2",   {31'd0, rx_valid[2]},  32'd0);
        check("mr_stall", {28'd0, stall_out},    32'd0);
        reset = 1'b0;
        tick();

        // Node 0 sends to dest 3 (all-ones)
        bus_gnt = 4'b0001;
        push(0, 8'h5A, 2'd3, 1'b1);
        wait_rx(3);
        for (int k = 0; k < 3; k++) tick();
        check("bc_n0", {31'd0, rx_valid[0]}, 32'd0);
`ifdef BUS_BROADCAST_EN
        pop(1, 8'h5A, 2'd0, 1'b1);
        pop(2, 8'h5A, 2'd0, 1'b1);
`else
        check("bc_n1", {31'd0, rx_valid[1]}, 32'd0);
        check("bc_n2", {31'd0, rx_valid[2]}, 32'd0);
`endif
        pop(3, 8'h5A, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
